ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite memory slave that sits directly downstream of the AHB master on the same HCLK bus. It consumes HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA and returns HRDATA/HREADYOUT/HRESP.
- Word-organised SRAM with byte-lane writes.
- Programmable wait states.
- Two-cycle ERROR response for illegal accesses.

Parameters:
ADDR_W, 8, word-address bits; memory depth 2^ADDR_W 32-bit words (byte range 0 .. 4*2^ADDR_W-1).
WAIT_STATES, 0, extra HREADYOUT-low cycles per OKAY transfer; legal range 0..7.

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  32  byte address (address phase)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size; 000 byte, 001 half, 010 word
HBURST  in  3  burst type; not used for decode, addresses taken as presented
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-wide ready; address phase is valid only when high
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Accept: at a rising edge where HSEL & HREADY & HTRANS[1]=1, register the address, write flag and size.
  - IDLE/BUSY, or HSEL=0: no data phase; the slave stays/returns to ST_IDLE with an OKAY zero-wait response.
- Illegal access is any of:
  - HSIZE > 010;
  - half-word with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR[31:2] >= 2^ADDR_W.
- FSM states, with outputs as registered state decodes:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
  - ST_WAIT: HREADYOUT=0, HRESP=0. A 3-bit counter is loaded with WAIT_STATES-1 on entry and decrements; the state exits to ST_LAST when it reaches 0.
  - ST_LAST: HREADYOUT=1, HRESP=0. Final data-phase cycle.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- Transitions on an accepted transfer, from ST_IDLE, ST_LAST or ST_ERR2:
  - legal and WAIT_STATES=0 -> ST_LAST;
  - legal and WAIT_STATES>0 -> ST_WAIT;
  - illegal -> ST_ERR1 (WAIT_STATES is ignored).
  - ST_ERR1 -> ST_ERR2 unconditionally.
  - From ST_LAST or ST_ERR2 with no accept -> ST_IDLE.
  - Back-to-back pipelined transfers therefore run at one per (WAIT_STATES+1) cycles.
- Write:
  - HWDATA is sampled only at the edge leaving ST_LAST.
  - Byte enables are little-endian:
    - byte: lane HADDR[1:0];
    - half: lanes {HADDR[1],0} and {HADDR[1],1};
    - word: all four lanes.
  - Unselected bytes are unchanged.
  - An ERROR write never modifies memory.
- Read:
  - HRDATA is loaded with the full 32-bit word at the edge entering ST_LAST, so it is valid throughout ST_LAST.
  - HRDATA holds its value afterwards; it is not zeroed on writes or errors.
- Simultaneous events: if a read loads HRDATA at the same edge a write commits to the same word (only possible with WAIT_STATES=0), HRDATA returns the merged new bytes (write-through forwarding).
- Latency: OKAY read/write completes WAIT_STATES+1 cycles after the address-phase edge. ERROR completes 2 cycles after it.
- Reset: state=ST_IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - Memory contents are not reset.
  - A write in its data phase when HRESET asserts is discarded.
  - A transfer presented in the same cycle as HRESET is ignored.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes (TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ);
  - HSIZE codes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - HBURST codes;
  - HRESP codes (RSP_OKAY, RSP_ERROR).
- FSM state encoding is local to the module.
- Sub-module sram_byte_mem: 2^ADDR_W x 32 array with a 4-bit byte-enable synchronous write and combinational read port. The FSM, decode and forwarding logic stay in ahb_sram_slave.

Test Plan:
- WAIT_STATES=0:
  - NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ word read @0x10 pipelined directly behind it -> forwarded HRDATA=0xDEADBEEF;
  - HREADYOUT stays 1 throughout.
- Byte writes 0x11 @0x21, then half-word write 0xBBAA @0x22 over an existing word 0x00000000 @0x20 -> word read @0x20 returns 0xBBAA1100.
- WAIT_STATES=2: word read @0x04 -> HREADYOUT 0,0,1 in the cycles after the address phase; HRDATA valid in the third cycle; HRESP=0 in all three.
- Misaligned word write @0x02 and out-of-range read @(4*2^ADDR_W) -> HREADYOUT/HRESP sequence (0,1) then (1,1); memory @0x00 unchanged on read-back.
- 4-beat INCR4 write at 0x40 with BUSY inserted after beat 2 -> BUSY gets zero-wait OKAY; words 0x40..0x4C hold beat data.
- Assert HRESET while in ST_WAIT of a write -> next cycle HREADYOUT=1, HRESP=0; target word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite bus encodings shared by the SRAM slave and its bench.
// Also provides the little-endian byte-lane enable helper.
package ahb_pkg;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    localparam logic [2:0] BR_SINGLE = 3'b000;
    localparam logic [2:0] BR_INCR   = 3'b001;
    localparam logic [2:0] BR_WRAP4  = 3'b010;
    localparam logic [2:0] BR_INCR4  = 3'b011;
    localparam logic [2:0] BR_WRAP8  = 3'b100;
    localparam logic [2:0] BR_INCR8  = 3'b101;
    localparam logic [2:0] BR_WRAP16 = 3'b110;
    localparam logic [2:0] BR_INCR16 = 3'b111;

    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        if (size == SZ_BYTE)      be = 4'b0001 << lane;
        else if (size == SZ_HALF) be = lane[1] ? 4'b1100 : 4'b0011;
        return be;
    endfunction

endpackage

// File: rtl/sram_byte_mem.sv
// Word-organised SRAM: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module sram_byte_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response
// and write-through forwarding when a read samples a word being written.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_e;

    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [31:0]       hrdata_q, hrdata_d;

    logic              take, illegal, wr_en, rd_load;
    logic [3:0]        wr_be;
    logic [ADDR_W-1:0] raddr;
    logic [31:0]       mem_rdata;
    logic              unused_bits;

    assign unused_bits = ^{HTRANS[0], HBURST};

    assign take = HSEL & HREADY & HTRANS[1]
                & (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);

    assign illegal = (HSIZE > SZ_WORD)
                   | ((HSIZE == SZ_HALF) & HADDR[0])
                   | ((HSIZE == SZ_WORD) & (HADDR[1:0] != 2'b00))
                   | (|HADDR[31:ADDR_W+2]);

    // A reset arriving during the final data-phase cycle discards the write.
    assign wr_en = (state_q == ST_LAST) & write_q & ~HRESET;
    assign wr_be = byte_en(size_q, lane_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_LAST;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_LAST, ST_ERR2: state_d = ST_IDLE;
            default: ;
        endcase
        if (take) begin
            waddr_d = HADDR[ADDR_W+1:2];
            lane_d  = HADDR[1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            if (illegal) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_LAST;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WS_M1;
            end
        end
    end

    // Reads sample at the edge entering ST_LAST: straight from the bus when
    // there are no wait states, otherwise from the registered address.
    always_comb begin
        raddr   = (state_q == ST_WAIT) ? waddr_q : HADDR[ADDR_W+1:2];
        rd_load = (state_d == ST_LAST) & ((state_q == ST_WAIT) ? ~write_q : ~HWRITE);
        hrdata_d = hrdata_q;
        if (rd_load) begin
            for (int b = 0; b < 4; b++) begin
                hrdata_d[8*b +: 8] = (wr_en && wr_be[b] && waddr_q == raddr)
                                   ? HWDATA[8*b +: 8] : mem_rdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            waddr_q  <= '0;
            lane_q   <= 2'd0;
            size_q   <= SZ_BYTE;
            write_q  <= 1'b0;
            hrdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    sram_byte_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk_i   (HCLK),
        .we_i    (wr_en),
        .be_i    (wr_be),
        .waddr_i (waddr_q),
        .wdata_i (HWDATA),
        .raddr_i (raddr),
        .rdata_o (mem_rdata)
    );

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? RSP_ERROR : RSP_OKAY;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one two-wait-state
// instance share the bus; read data is checked through an expected queue.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sel0, sel2;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic        HREADY;
    logic [31:0] rdata0, rdata2;
    logic        ready0, ready2, resp0, resp2;
    logic        act;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] beat_d [4];

    always #5 HCLK = ~HCLK;

    assign HREADY = act ? ready2 : ready0;

    ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] tr, input logic w,
                              input logic [2:0] sz);
        sel0   = ~act;
        sel2   = act;
        HADDR  = a;
        HTRANS = tr;
        HWRITE = w;
        HSIZE  = sz;
    endtask

    // Single transfer: checks HRESP every data-phase cycle, total latency,
    // and for OKAY reads the data popped from the expected queue.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic err, input logic [31:0] rexp,
                        input string tag);
        int n;
        int lat;
        logic [31:0] ry, rs, rd;
        lat = err ? 2 : (act ? 3 : 1);
        addr_phase(a, TR_NONSEQ, w, sz);
        if (!w && !err) exp_q.push_back(rexp);
        step();
        HTRANS = TR_IDLE;
        HWDATA = wd;
        n = 1;
        ry = {31'd0, HREADY};
        rs = {31'd0, act ? resp2 : resp0};
        chk({tag, "_resp"}, rs, {31'd0, err});
        while (ry == 0 && n < 20) begin
            step();
            n++;
            ry = {31'd0, HREADY};
            rs = {31'd0, act ? resp2 : resp0};
            chk({tag, "_resp"}, rs, {31'd0, err});
        end
        chk({tag, "_latency"}, n, lat);
        if (!w && !err) begin
            rd = act ? rdata2 : rdata0;
            chk({tag, "_rdata"}, rd, exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        act = 1'b0; sel0 = 1'b0; sel2 = 1'b0;
        HADDR = '0; HTRANS = TR_IDLE; HWRITE = 1'b0; HSIZE = SZ_WORD;
        HBURST = BR_SINGLE; HWDATA = '0;
        HRESET = 1'b1;
        step();
        step();
        chk("rst_ready0", {31'd0, ready0}, 32'd1);
        chk("rst_resp0",  {31'd0, resp0},  32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_ready2", {31'd0, ready2}, 32'd1);
        HRESET = 1'b0;
        step();

        // Zero-wait write then read of the same word, pipelined: forwarded data.
        addr_phase(32'h10, TR_NONSEQ, 1'b1, SZ_WORD);
        step();
        chk("fwd_ready_w", {31'd0, ready0}, 32'd1);
        HWDATA = 32'hDEADBEEF;
        addr_phase(32'h10, TR_NONSEQ, 1'b0, SZ_WORD);
        exp_q.push_back(32'hDEADBEEF);
        step();
        chk("fwd_ready_r", {31'd0, ready0}, 32'd1);
        chk("fwd_rdata", rdata0, exp_q.pop_front());
        HTRANS = TR_IDLE;
        step();
        chk("fwd_ready_idle", {31'd0, ready0}, 32'd1);

        // Byte and half-word lanes merged over a zeroed word.
        xfer(32'h20, 1'b1, SZ_WORD, 32'h0000_0000, 1'b0, 32'h0, "zero20");
        xfer(32'h21, 1'b1, SZ_BYTE, 32'h0000_1100, 1'b0, 32'h0, "byte21");
        xfer(32'h22, 1'b1, SZ_HALF, 32'hBBAA_0000, 1'b0, 32'h0, "half22");
        xfer(32'h20, 1'b0, SZ_WORD, 32'h0, 1'b0, 32'hBBAA1100, "rd20");

        // Illegal accesses: misaligned word write, out-of-range read.
        xfer(32'h00, 1'b1, SZ_WORD, 32'hCAFEF00D, 1'b0, 32'h0, "init00");
        xfer(32'h02, 1'b1, SZ_WORD, 32'hFFFFFFFF, 1'b1, 32'h0, "err_mis");
        xfer(32'h400, 1'b0, SZ_WORD, 32'h0, 1'b1, 32'h0, "err_oor");
        chk("err_hold_rdata", rdata0, 32'hBBAA1100);
        xfer(32'h00, 1'b0, SZ_WORD, 32'h0, 1'b0, 32'hCAFEF00D, "rd00");
        xfer(32'h01, 1'b0, SZ_HALF, 32'h0, 1'b1, 32'h0, "err_half");

        // INCR4 write with a BUSY cycle after the second beat.
        for (int i = 0; i < 4; i++) beat_d[i] = $urandom_range(32'h7FFF_FFFF, 0);
        HBURST = BR_INCR4;
        addr_phase(32'h40, TR_NONSEQ, 1'b1, SZ_WORD);
        step();
        HWDATA = beat_d[0];
        addr_phase(32'h44, TR_SEQ, 1'b1, SZ_WORD);
        step();
        HWDATA = beat_d[1];
        addr_phase(32'h48, TR_BUSY, 1'b1, SZ_WORD);
        step();
        chk("busy_ready", {31'd0, ready0}, 32'd1);
        chk("busy_resp",  {31'd0, resp0},  32'd0);
        addr_phase(32'h48, TR_SEQ, 1'b1, SZ_WORD);
        step();
        HWDATA = beat_d[2];
        addr_phase(32'h4C, TR_SEQ, 1'b1, SZ_WORD);
        step();
        HWDATA = beat_d[3];
        HTRANS = TR_IDLE;
        HBURST = BR_SINGLE;
        step();
        for (int i = 0; i < 4; i++)
            xfer(32'h40 + 32'(4*i), 1'b0, SZ_WORD, 32'h0, 1'b0, beat_d[i], "incr4_rd");

        // Two-wait-state instance.
        sel0 = 1'b0;
        HTRANS = TR_IDLE;
        step();
        act = 1'b1;
        xfer(32'h04, 1'b1, SZ_WORD, 32'h12345678, 1'b0, 32'h0, "ws2_wr04");
        addr_phase(32'h04, TR_NONSEQ, 1'b0, SZ_WORD);
        exp_q.push_back(32'h12345678);
        step();
        HTRANS = TR_IDLE;
        chk("ws2_c1_ready", {31'd0, ready2}, 32'd0);
        chk("ws2_c1_resp",  {31'd0, resp2},  32'd0);
        step();
        chk("ws2_c2_ready", {31'd0, ready2}, 32'd0);
        chk("ws2_c2_resp",  {31'd0, resp2},  32'd0);
        step();
        chk("ws2_c3_ready", {31'd0, ready2}, 32'd1);
        chk("ws2_c3_resp",  {31'd0, resp2},  32'd0);
        chk("ws2_c3_rdata", rdata2, exp_q.pop_front());
        xfer(32'h06, 1'b1, SZ_WORD, 32'h0, 1'b1, 32'h0, "ws2_err");

        // Reset while a write sits in its wait states.
        xfer(32'h08, 1'b1, SZ_WORD, 32'h5555AAAA, 1'b0, 32'h0, "ws2_wr08");
        addr_phase(32'h08, TR_NONSEQ, 1'b1, SZ_WORD);
        step();
        chk("rstw_wait", {31'd0, ready2}, 32'd0);
        HTRANS = TR_IDLE;
        HWDATA = 32'hFFFFFFFF;
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("rstw_ready", {31'd0, ready2}, 32'd1);
        chk("rstw_resp",  {31'd0, resp2},  32'd0);
        chk("rstw_rdata", rdata2, 32'd0);
        step();
        xfer(32'h08, 1'b0, SZ_WORD, 32'h0, 1'b0, 32'h5555AAAA, "rstw_rd08");

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
